// File: rtl/burst_req_sequencer.sv
// burst_req_sequencer: buffers burst requests in a FIFO and issues
// BURST_LEN-cycle burst_en pulses, each followed by a guaranteed low gap.
// Ports: clk, rst (sync, active-high), req_valid/req_ready/req_addr in,
//        burst_en, addr_out, beat_cnt, burst_done, busy out.
// Option: define BURST_ADDR_ALIGN_EN to align burst starts to BURST_LEN.
module burst_req_sequencer #(
   parameter int ADDR_WIDTH = 16,
   parameter int BURST_LEN  = 8,
   parameter int FIFO_DEPTH = 4,
   parameter int GAP_CYCLES = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   output logic                  burst_en,
   output logic [ADDR_WIDTH-1:0] addr_out,
   output logic [3:0]            beat_cnt,
   output logic                  burst_done,
   output logic                  busy
);

   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = PW + 1;
   localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

   localparam logic [3:0]    LAST_BEAT = 4'(BURST_LEN - 1);
   localparam logic [GW-1:0] GAP_LOAD  = GW'(GAP_CYCLES - 1);
   localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      IDLE,
      BURST,
      GAP
   } state_t;

   logic [ADDR_WIDTH-1:0] mem [FIFO_DEPTH];
   logic [PW-1:0]         wr_ptr;
   logic [PW-1:0]         rd_ptr;
   logic [CW-1:0]         count;
   logic                  push;
   logic                  pop;
   logic [ADDR_WIDTH-1:0] head_addr;
   logic [ADDR_WIDTH-1:0] load_addr;

   state_t                state_q, state_d;
   logic                  burst_en_q, burst_en_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [3:0]            beat_q, beat_d;
   logic [GW-1:0]         gap_q, gap_d;

   // Ready comes only from registered occupancy, never from req_valid.
   assign req_ready = (count != FULL_CNT);
   assign push      = req_valid && req_ready;
   assign head_addr = mem[rd_ptr];

`ifdef BURST_ADDR_ALIGN_EN
   localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK =
      ~ADDR_WIDTH'(BURST_LEN - 1);
   assign load_addr = head_addr & ALIGN_MASK;
`else
   assign load_addr = head_addr;
`endif

   // Storage is not reset; pointers and count define validity.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= req_addr;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         burst_en_q <= 1'b0;
         addr_q     <= '0;
         beat_q     <= '0;
         gap_q      <= '0;
      end else begin
         state_q    <= state_d;
         burst_en_q <= burst_en_d;
         addr_q     <= addr_d;
         beat_q     <= beat_d;
         gap_q      <= gap_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      burst_en_d = burst_en_q;
      addr_d     = addr_q;
      beat_d     = beat_q;
      gap_d      = gap_q;
      pop        = 1'b0;
      case (state_q)
         IDLE: begin
            if (count != '0) begin
               pop        = 1'b1;
               addr_d     = load_addr;
               burst_en_d = 1'b1;
               beat_d     = '0;
               state_d    = BURST;
            end
         end
         BURST: begin
            if (beat_q == LAST_BEAT) begin
               burst_en_d = 1'b0;
               gap_d      = GAP_LOAD;
               state_d    = GAP;
            end else begin
               beat_d = beat_q + 1'b1;
            end
         end
         GAP: begin
            // Counts GAP_CYCLES cycles down to zero, then back to IDLE.
            if (gap_q == '0) begin
               state_d = IDLE;
            end else begin
               gap_d = gap_q - 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign burst_en   = burst_en_q;
   assign addr_out   = addr_q;
   assign beat_cnt   = beat_q;
   assign burst_done = (state_q == BURST) && (beat_q == LAST_BEAT);
   assign busy       = (state_q != IDLE) || (count != '0);

endmodule
